// File: rtl/vga_page_scanner_pkg.sv
// Shared VGA 640x480@60 timing constants, bus widths and
// the sync/active bundle carried down the alignment pipeline.
package vga_page_scanner_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int PIX_W  = 12;
    localparam int ADDR_W = 17;
    localparam int PAGE_W = 10;
    localparam int POS_W  = 10;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PAGE_W-1:0] page_t;
    typedef logic [POS_W-1:0]  pos_t;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic act;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// h/v raster counters with raw (unpipelined) sync and active flag.
// Ports: clk, rst (sync, active-high); h, v counters; line_end,
// frame_end wrap strobes; sync_raw {hs_n, vs_n, act} for counter state.
module vga_timing
    import vga_page_scanner_pkg::*;
#(
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_SYN   = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_SYN   = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic  clk,
    input  logic  rst,
    output pos_t  h,
    output pos_t  v,
    output logic  line_end,
    output logic  frame_end,
    output sync_t sync_raw
);

    localparam int HT = H_ACT + H_FRONT + H_SYN + H_BACK;
    localparam int VT = V_ACT + V_FRONT + V_SYN + V_BACK;

    localparam pos_t H_LAST   = pos_t'(HT - 1);
    localparam pos_t V_LAST   = pos_t'(VT - 1);
    localparam pos_t H_VIS    = pos_t'(H_ACT);
    localparam pos_t V_VIS    = pos_t'(V_ACT);
    localparam pos_t HS_START = pos_t'(H_ACT + H_FRONT);
    localparam pos_t HS_END   = pos_t'(H_ACT + H_FRONT + H_SYN);
    localparam pos_t VS_START = pos_t'(V_ACT + V_FRONT);
    localparam pos_t VS_END   = pos_t'(V_ACT + V_FRONT + V_SYN);

    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= frame_end ? '0 : v + pos_t'(1);
        end else begin
            h <= h + pos_t'(1);
        end
    end

    always_comb begin
        sync_raw      = SYNC_IDLE;
        sync_raw.hs_n = !((h >= HS_START) && (h < HS_END));
        sync_raw.vs_n = !((v >= VS_START) && (v < VS_END));
        sync_raw.act  = (h < H_VIS) && (v < V_VIS);
    end

endmodule

// File: rtl/vga_page_scanner.sv
// Scans a 2x-upscaled page image out to VGA, latching the page index
// only at the start of vertical blank so a visible frame never tears.
// Ports: clk, rst (sync, active-high); page_req requested page;
// rgb_in pixel back from storage; cnt latched page and address_sig
// image address to storage; vga_rgb, hsync, vsync to the DAC pins;
// frame_tick pulses the cycle cnt is (re)latched.
module vga_page_scanner
    import vga_page_scanner_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int PIPE    = 3,
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_SYN   = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_SYN   = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAGE_W-1:0] page_req,
    input  logic [PIX_W-1:0]  rgb_in,
    output logic [PAGE_W-1:0] cnt,
    output logic [ADDR_W-1:0] address_sig,
    output logic [PIX_W-1:0]  vga_rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_tick
);

    localparam addr_t ROW_STEP = addr_t'(IMG_W);
    localparam addr_t ADDR_MAX = addr_t'(IMG_W * IMG_H - 1);
    localparam pos_t  V_VIS    = pos_t'(V_ACT);
    localparam pos_t  V_LATCH  = pos_t'(V_ACT - 1);

    pos_t  h;
    pos_t  v;
    logic  line_end;
    logic  frame_end;
    sync_t sync_raw;

    vga_timing #(
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYN   (H_SYN),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYN   (V_SYN),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .h         (h),
        .v         (v),
        .line_end  (line_end),
        .frame_end (frame_end),
        .sync_raw  (sync_raw)
    );

    // row_base tracks (v>>1)*IMG_W: it steps after every odd
    // visible line so each source row is shown on two lines.
    addr_t row_base;
    addr_t addr_sum;
    addr_t addr_next;
    logic  latch;

    assign addr_sum  = row_base + addr_t'(h >> 1);
    assign addr_next = (addr_sum > ADDR_MAX) ? ADDR_MAX : addr_sum;

    // Looks one cycle ahead so cnt and frame_tick change exactly
    // when the counters show h=0, v=V_ACT.
    assign latch = line_end && (v == V_LATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base    <= '0;
            address_sig <= '0;
        end else begin
            if (frame_end) begin
                row_base <= '0;
            end else if (line_end && v[0] && (v < V_VIS)) begin
                row_base <= row_base + ROW_STEP;
            end
            address_sig <= sync_raw.act ? addr_next : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= latch;
            if (latch) begin
                cnt <= page_req;
            end
        end
    end

    // Sync/active delay line; the pixel register reads the stage
    // one short of the end so vga_rgb lands with the sync pins.
    sync_t pipe_q [PIPE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
            vga_rgb <= '0;
        end else begin
            pipe_q[0] <= sync_raw;
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            vga_rgb <= pipe_q[PIPE-2].act ? rgb_in : '0;
        end
    end

    assign hsync = pipe_q[PIPE-1].hs_n;
    assign vsync = pipe_q[PIPE-1].vs_n;

endmodule
